// File: rtl/lbuf_rmw_add_pkg.sv
// Shared constants for the line-buffer RMW path: CRY field layout, field widths, default AW.
package lbuf_pkg;
  localparam int LBUF_AW = 9;
  localparam int PIX_W   = 16;
  localparam int Y_W     = 8;
  localparam int C_W     = 4;
  localparam int R_W     = 4;
  localparam int Y_LSB   = 0;
  localparam int R_LSB   = 8;
  localparam int C_LSB   = 12;

  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/lbuf_rmw_add_if.sv
// Pixel request handshake plus line-buffer RAM port, bundled; slave is the RMW unit's view.
interface lbuf_rmw_add_if #(parameter int AW = 9);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [15:0]   in_data;
  logic          in_add;
  logic          mem_busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  modport slave (
    input  in_valid, in_addr, in_data, in_add, mem_busy, rd_data,
    output in_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
  modport master (
    output in_valid, in_addr, in_data, in_add, mem_busy, rd_data,
    input  in_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/lbuf_cry_sat.sv
// Combinational CRY saturating adder: unsigned stored field plus signed delta, clamped per field.
module lbuf_sat_field #(parameter int W = 4) (
  input  logic [W-1:0] old_v,
  input  logic [W-1:0] delta,
  output logic [W-1:0] res,
  output logic         sat
);
  logic [W:0] sum;
  assign sum = {1'b0, old_v} + {1'b0, delta};
  // Carry disagreeing with the delta sign means we left [0, 2**W-1]; the carry picks the rail.
  assign sat = sum[W] ^ delta[W-1];
  assign res = sat ? {W{sum[W]}} : sum[W-1:0];
endmodule

module lbuf_cry_sat
  import lbuf_pkg::*;
(
  input  pix_t old_pix,
  input  pix_t delta,
  output pix_t res,
  output logic sat
);
  logic [1:0] nib_sat;
  logic       y_sat;

  for (genvar i = 0; i < 2; i++) begin : g_nib
    localparam int LSB = (i == 0) ? R_LSB : C_LSB;
    lbuf_sat_field #(.W(C_W)) u_fld (
      .old_v (old_pix[LSB +: C_W]),
      .delta (delta[LSB +: C_W]),
      .res   (res[LSB +: C_W]),
      .sat   (nib_sat[i])
    );
  end

  lbuf_sat_field #(.W(Y_W)) u_y (
    .old_v (old_pix[Y_LSB +: Y_W]),
    .delta (delta[Y_LSB +: Y_W]),
    .res   (res[Y_LSB +: Y_W]),
    .sat   (y_sat)
  );

  assign sat = (|nib_sat) | y_sat;
endmodule

// File: rtl/lbuf_rmw_add.sv
// Two-stage read-modify-write unit in front of the line-buffer RAM (CRY add-blend or plain write).
// Optional saturation counter enabled by defining LBUF_RMW_STATS_EN.
module lbuf_rmw_add
  import lbuf_pkg::*;
#(
  parameter int AW = LBUF_AW
) (
  input  logic          sys_clk,
  input  logic          resetl,
  lbuf_rmw_add_if.slave bus,
  output logic          busy,
  input  logic          sat_clr,
  output logic [15:0]   sat_count
);
  localparam int STAGES = 2;

  // vld_pipe[0] = S1, vld_pipe[1] = S2
  logic [STAGES-1:0] vld_pipe;
  logic              accept;
  logic [AW-1:0]     s1_addr, s2_addr, wb_addr;
  pix_t              s1_data, s2_data, wb_data;
  logic              s1_add;
  logic              wb_vld;
  pix_t              operand, sum_pix, result;
  logic              sat;

  assign bus.in_ready = ~bus.mem_busy;
  assign accept       = bus.in_valid & ~bus.mem_busy;
  assign bus.rd_en    = accept & bus.in_add;
  assign bus.rd_addr  = bus.in_addr;

  // The RAM returns pre-write data, so the two writes not yet visible to this read come from S2 and WB.
  always_comb begin
    operand = bus.rd_data;
    if (vld_pipe[1] && s2_addr == s1_addr)
      operand = s2_data;
    else if (wb_vld && wb_addr == s1_addr)
      operand = wb_data;
  end

  lbuf_cry_sat u_sat (
    .old_pix (operand),
    .delta   (s1_data),
    .res     (sum_pix),
    .sat     (sat)
  );

  assign result = s1_add ? sum_pix : s1_data;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      vld_pipe <= '0;
      s1_addr  <= '0;
      s1_data  <= '0;
      s1_add   <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
      wb_vld   <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) begin
        s1_addr <= bus.in_addr;
        s1_data <= bus.in_data;
        s1_add  <= bus.in_add;
      end
      if (vld_pipe[0]) begin
        s2_addr <= s1_addr;
        s2_data <= result;
      end
      wb_vld  <= vld_pipe[1];
      wb_addr <= s2_addr;
      wb_data <= s2_data;
    end
  end

  assign bus.wr_en   = vld_pipe[1];
  assign bus.wr_addr = s2_addr;
  assign bus.wr_data = s2_data;
  assign busy        = |vld_pipe;

`ifdef LBUF_RMW_STATS_EN
  logic [15:0] sat_cnt;
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= '0;
    else if (vld_pipe[0] && s1_add && sat && sat_cnt != 16'hFFFF)
      sat_cnt <= sat_cnt + 16'd1;
  end
  assign sat_count = sat_cnt;
`else
  logic unused_stats;
  assign unused_stats = sat_clr ^ sat;
  assign sat_count    = '0;
`endif
endmodule
